// File: rtl/data_mem_sized_if.sv
// data_mem_sized_if: request/response bundle between the memory stage and the
// sized data memory. The master issues an access with req and waits for a
// one-cycle ready pulse carrying the load result and the misaligned flag.
interface data_mem_sized_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        misaligned;

  modport master (
    output req, we, size, sign_ext, addr, wdata,
    input  ready, rdata, misaligned
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata,
    output ready, rdata, misaligned
  );
endinterface

// File: rtl/data_mem_sized.sv
// data_mem_sized: 2^ADDR_W x 32 data memory with byte/half/word loads and
// stores, sign/zero extension on loads, WAIT_CYCLES wait states before every
// access and a req/ready handshake.
// Optional feature macro: DMEM_MISALIGN_CHECK_EN. When it is defined,
// misaligned halfword and word accesses are flagged, stores are suppressed and
// loads return zero. When it is undefined, the offending low address bits are
// ignored and misaligned is tied low.
module data_mem_sized #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_sized_if.slave bus
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);
  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t state;
  state_t state_nxt;

  // Wait-state countdown.
  logic [7:0] wait_cnt;

  // Access parameters captured when a request is accepted.
  logic              we_q;
  logic [1:0]        size_q;
  logic              sign_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;

  // Storage array.
  logic [31:0] mem [DEPTH];

  // Registered response.
  logic        ready_q;
  logic        mis_q;
  logic [31:0] rdata_q;

  // Datapath signals computed in the output process.
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       ld_val;
  logic [3:0]        wr_mask;
  logic [31:0]       wr_data;
  logic              do_write;
  logic              mis_acc;
  logic              accept;

  // Address bits above the array index alias onto the same words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

  // A request is only looked at while idle; anything else on req is ignored.
  assign accept = (state == S_IDLE) && bus.req;

  // Alignment check on the captured access.
`ifdef DMEM_MISALIGN_CHECK_EN
  assign mis_acc = ((size_q == SZ_HALF) && addr_q[0]) ||
                   (size_q[1] && (addr_q[1:0] != 2'b00));
`else
  assign mis_acc = 1'b0;
`endif

  // State register: reset wins over any pending request.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> (WAIT ->) ACCESS -> IDLE.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (bus.req) begin
          state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (wait_cnt == 8'd1) begin
          state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath logic: lane selection, extension and byte write mask.
  always_comb begin
    word_idx = addr_q[ADDR_W+1:2];
    rd_word  = mem[word_idx];
    rd_byte  = rd_word[{addr_q[1:0], 3'b000} +: 8];
    rd_half  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    ld_val   = rd_word;
    wr_mask  = 4'b1111;
    wr_data  = wdata_q;
    unique case (size_q)
      SZ_BYTE: begin
        ld_val  = {{24{sign_q & rd_byte[7]}}, rd_byte};
        wr_mask = 4'b0001 << addr_q[1:0];
        wr_data = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        ld_val  = {{16{sign_q & rd_half[15]}}, rd_half};
        wr_mask = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata_q[15:0]}};
      end
      default: begin
        // Word and the reserved encoding both use the full word.
        ld_val  = rd_word;
        wr_mask = 4'b1111;
        wr_data = wdata_q;
      end
    endcase
    do_write = (state == S_ACCESS) && we_q && !mis_acc && !reset;
  end

  // Wait-state counter: loaded on accept, counts down while waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= 8'd0;
    end else if (accept) begin
      wait_cnt <= WAIT_INIT;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt - 8'd1;
    end
  end

  // Capture the access so the inputs are free to change while busy.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.we;
      size_q  <= bus.size;
      sign_q  <= bus.sign_ext;
      addr_q  <= bus.addr[ADDR_W+1:0];
      wdata_q <= bus.wdata;
    end
  end

  // Byte-masked store at the ACCESS edge; untouched lanes keep their value.
  // NOTE: the array is deliberately not reset -- reset only clears control
  // state, and a resettable array could not map onto RAM.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) begin
          mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Response registers: one-cycle ready pulse; rdata only moves on loads.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ready_q <= (state == S_ACCESS);
      mis_q   <= (state == S_ACCESS) && mis_acc;
      if ((state == S_ACCESS) && !we_q) begin
        rdata_q <= mis_acc ? 32'd0 : ld_val;
      end
    end
  end

  assign bus.ready      = ready_q;
  assign bus.misaligned = mis_q;
  assign bus.rdata      = rdata_q;

endmodule
